// File: rtl/deserializer_if.sv
// ---------------------------------------------------------------------------
// deserializer_if
// Groups the parallel-side signals of the deserializer: the received word,
// the valid/ack handshake, the error pulses, the good-frame counter and the
// busy flag.
//   master : deserializer side (drives word, status and counter; reads ack)
//   slave  : consumer side (reads word, status and counter; drives ack)
// Parameters:
//   DATA_W : payload bits per frame
//   CNT_W  : width of the good-frame counter
// ---------------------------------------------------------------------------
interface deserializer_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ack;
    logic              parity_err;
    logic              frame_err;
    logic              overrun_err;
    logic [CNT_W-1:0]  frame_cnt;
    logic              busy;

    modport master (
        output data_out,
        output data_valid,
        input  data_ack,
        output parity_err,
        output frame_err,
        output overrun_err,
        output frame_cnt,
        output busy
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ack,
        input  parity_err,
        input  frame_err,
        input  overrun_err,
        input  frame_cnt,
        input  busy
    );
endinterface

// File: rtl/deserializer.sv
// ---------------------------------------------------------------------------
// deserializer
// Receives frames from a serial line in the same clock domain, one bit per
// clock: start bit 1, DATA_W data bits MSB first, even-parity bit, stop
// bit 0. Good words are loaded into a single holding register with a
// valid/ack handshake; bad or unstorable words raise one-cycle error pulses.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   signal_in : serial line, sampled directly every rising edge
//   bus       : deserializer_if.master (data_out, data_valid, data_ack,
//               parity_err, frame_err, overrun_err, frame_cnt, busy)
// ---------------------------------------------------------------------------
module deserializer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           signal_in,
    deserializer_if.master bus
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state_q,       state_d;
    logic [BIT_W-1:0]  bit_cnt_q,     bit_cnt_d;
    logic [DATA_W-1:0] shift_q,       shift_d;
    logic              par_q,         par_d;
    logic [DATA_W-1:0] data_out_q,    data_out_d;
    logic              data_valid_q,  data_valid_d;
    logic              parity_err_q,  parity_err_d;
    logic              frame_err_q,   frame_err_d;
    logic              overrun_err_q, overrun_err_d;
    logic [CNT_W-1:0]  frame_cnt_q,   frame_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        parity_err_d  = 1'b0;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        // An ack only consumes a word that is actually held; a good word
        // completing on the same edge overrides this below.
        if (data_valid_q && bus.data_ack) begin
            data_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (signal_in) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                shift_d = {shift_q[DATA_W-2:0], signal_in};
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = PARITY;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            PARITY: begin
                par_d   = signal_in;
                state_d = STOP;
            end
            STOP: begin
                // Always return to IDLE: the stop bit itself can never be
                // taken as the next start bit.
                state_d = IDLE;
                if (signal_in) begin
                    frame_err_d = 1'b1;
                end else if ((^shift_q) != par_q) begin
                    parity_err_d = 1'b1;
                end else if (!data_valid_q || bus.data_ack) begin
                    data_out_d   = shift_q;
                    data_valid_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                end else begin
                    overrun_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.parity_err  = parity_err_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_err_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_deserializer.sv
// ---------------------------------------------------------------------------
// tb_deserializer
// Bench for deserializer. Two instances share the serial line, ack and
// reset: one with a 16-bit frame counter, one with a 4-bit counter to
// observe wrap-around. Expected words are queued as frames are sent and
// matched against the 16-bit instance whenever its counter advances.
// ---------------------------------------------------------------------------
module tb_deserializer;

    logic clk;
    logic rst_n;
    logic signal_in;

    deserializer_if #(.DATA_W(8), .CNT_W(16)) bus ();
    deserializer_if #(.DATA_W(8), .CNT_W(4))  bus_w ();

    deserializer #(.DATA_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .signal_in (signal_in),
        .bus       (bus)
    );

    deserializer #(.DATA_W(8), .CNT_W(4)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .signal_in (signal_in),
        .bus       (bus_w)
    );

    int         n_tests;
    int         n_fail;
    logic [7:0] exp_q[$];
    logic [7:0] exp_word;
    logic [15:0] prev_cnt;
    logic       valid_at_parity;
    logic       busy_at_parity;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every counter advance must deliver the next queued word;
    // also at most one error pulse may be high in any cycle.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_cnt = bus.frame_cnt;
        end else if (bus.frame_cnt != prev_cnt) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got word %h, none expected", bus.data_out);
            end else begin
                exp_word = exp_q.pop_front();
                if (bus.data_out !== exp_word) begin
                    n_fail++;
                    $display("FAIL scoreboard_word: got %h want %h", bus.data_out, exp_word);
                end
            end
            prev_cnt = bus.frame_cnt;
        end
        if (rst_n && ($countones({bus.parity_err, bus.frame_err, bus.overrun_err}) > 1)) begin
            n_tests++;
            n_fail++;
            $display("FAIL one_error_only: got %b want at most one high",
                     {bus.parity_err, bus.frame_err, bus.overrun_err});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic set_ack(input logic v);
        bus.data_ack   = v;
        bus_w.data_ack = v;
    endtask

    // Drive one bit; returns 1 time unit after the edge that sampled it.
    task automatic send_bit(input logic b);
        signal_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_b, input logic ack_stop);
        send_bit(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit((^d) ^ par_flip);
        valid_at_parity = bus.data_valid;
        busy_at_parity  = bus.busy;
        set_ack(ack_stop);
        send_bit(stop_b);
        set_ack(1'b0);
        signal_in = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        signal_in = 1'b0;
        set_ack(1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.data_out, bus.data_valid, bus.parity_err, bus.frame_err,
             bus.overrun_err, bus.busy} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%b/%b%b%b/%b want all zero", bus.data_out,
                     bus.data_valid, bus.parity_err, bus.frame_err, bus.overrun_err, bus.busy);
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_frame_cnt: got %0d want 0", bus.frame_cnt);
        end
        rst_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_frame: got %b want 1", bus.busy);
        end
        // Assert reset between edges: outputs must clear without a clock.
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_busy: got %b want 0", bus.busy);
        end
        signal_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_good_frame();
        apply_reset();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (valid_at_parity !== 1'b0 || busy_at_parity !== 1'b1) begin
            n_fail++;
            $display("FAIL good_before_stop: got valid=%b busy=%b want valid=0 busy=1",
                     valid_at_parity, busy_at_parity);
        end
        n_tests++;
        if (bus.data_out !== 8'hA5 || bus.data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL good_word: got %h valid=%b want a5 valid=1", bus.data_out, bus.data_valid);
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL good_frame_cnt: got %0d want 1", bus.frame_cnt);
        end
        n_tests++;
        if ({bus.parity_err, bus.frame_err, bus.overrun_err, bus.busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL good_flags: got perr/ferr/oerr/busy=%b%b%b%b want 0000",
                     bus.parity_err, bus.frame_err, bus.overrun_err, bus.busy);
        end
    endtask

    task automatic test_ack();
        set_ack(1'b1);
        send_bit(1'b0);
        n_tests++;
        if (bus.data_valid !== 1'b0 || bus.data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL ack_consume: got %h valid=%b want a5 valid=0", bus.data_out, bus.data_valid);
        end
        send_bit(1'b0);
        n_tests++;
        if (bus.data_valid !== 1'b0 || bus.data_out !== 8'hA5 || bus.frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL ack_idle_ignored: got %h valid=%b cnt=%0d want a5 valid=0 cnt=1",
                     bus.data_out, bus.data_valid, bus.frame_cnt);
        end
        set_ack(1'b0);
    endtask

    task automatic test_parity_err();
        apply_reset();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if ({bus.parity_err, bus.frame_err, bus.overrun_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL parity_pulse: got perr/ferr/oerr=%b%b%b want 100",
                     bus.parity_err, bus.frame_err, bus.overrun_err);
        end
        n_tests++;
        if (bus.data_valid !== 1'b0 || bus.frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL parity_dropped: got valid=%b cnt=%0d want valid=0 cnt=0",
                     bus.data_valid, bus.frame_cnt);
        end
        send_bit(1'b0);
        n_tests++;
        if (bus.parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_one_cycle: got %b want 0", bus.parity_err);
        end
    endtask

    task automatic test_frame_err();
        apply_reset();
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if ({bus.parity_err, bus.frame_err, bus.overrun_err} !== 3'b010) begin
            n_fail++;
            $display("FAIL frame_pulse: got perr/ferr/oerr=%b%b%b want 010",
                     bus.parity_err, bus.frame_err, bus.overrun_err);
        end
        n_tests++;
        if (bus.busy !== 1'b0 || bus.data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_to_idle: got busy=%b valid=%b want 0 0", bus.busy, bus.data_valid);
        end
        send_bit(1'b0);
        n_tests++;
        if (bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_no_restart: got ferr=%b busy=%b want 0 0", bus.frame_err, bus.busy);
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (bus.overrun_err !== 1'b1 || bus.data_out !== 8'h11 || bus.data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_pulse: got oerr=%b data=%h valid=%b want 1 11 1",
                     bus.overrun_err, bus.data_out, bus.data_valid);
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL overrun_cnt: got %0d want 1", bus.frame_cnt);
        end
        send_bit(1'b0);
        n_tests++;
        if (bus.overrun_err !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_one_cycle: got %b want 0", bus.overrun_err);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (bus.data_out !== 8'h22 || bus.data_valid !== 1'b1 || bus.overrun_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ack_stop: got data=%h valid=%b oerr=%b want 22 1 0",
                     bus.data_out, bus.data_valid, bus.overrun_err);
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_cnt: got %0d want 2", bus.frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        apply_reset();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (bus.data_out !== 8'h5A || bus.frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got data=%h cnt=%0d want 5a 1", bus.data_out, bus.frame_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        logic [7:0] d;
        apply_reset();
        for (int k = 0; k < 17; k++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            send_frame(d, 1'b0, 1'b0, 1'b1);
            n_tests++;
            if ({bus_w.parity_err, bus_w.frame_err, bus_w.overrun_err} !== 3'b000
                || bus_w.data_out !== d) begin
                n_fail++;
                $display("FAIL wrap_frame_%0d: got data=%h errs=%b%b%b want %h 000", k,
                         bus_w.data_out, bus_w.parity_err, bus_w.frame_err, bus_w.overrun_err, d);
            end
        end
        n_tests++;
        if (bus_w.frame_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_cnt4: got %0d want 1", bus_w.frame_cnt);
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd17) begin
            n_fail++;
            $display("FAIL wrap_cnt16: got %0d want 17", bus.frame_cnt);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        prev_cnt  = '0;
        rst_n     = 1'b0;
        signal_in = 1'b0;
        set_ack(1'b0);

        test_reset();
        test_good_frame();
        test_ack();
        test_parity_err();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_cnt_wrap();
        repeat (2) send_bit(1'b0);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d words pending want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame (legal 4..16).
REQ-002 Parameter CNT_W, default 16, width of the good-frame counter.
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 signal_in  input  1  serial line from the generator, same clock domain, one bit per CLK, sampled directly on every rising edge (no synchronizer).
REQ-006 data_ack  input  1  consumer accepts data_out; honoured only while data_valid=1.
REQ-007 data_out  output  DATA_W  last accepted payload, MSB = first received data bit.
REQ-008 data_valid  output  1  data_out holds an unconsumed word.
REQ-009 parity_err  output  1  one-cycle pulse: parity mismatch, word dropped.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit not 0, word dropped.
REQ-011 overrun_err  output  1  one-cycle pulse: good word completed while holding register full and not acked, new word dropped.
REQ-012 frame_cnt  output  CNT_W  count of words loaded into data_out.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Frame format: line idles 0; start bit 1; DATA_W data bits MSB first; one even-parity bit (XOR of data bits); stop bit 0; total DATA_W+3 bits.
REQ-015 FSM states IDLE, DATA, PARITY, STOP; state register and a bit counter of ceil(log2(DATA_W)) bits.
REQ-016 IDLE: signal_in=1 sampled -> DATA, bit counter cleared; signal_in=0 -> stay IDLE.
REQ-017 DATA: each edge shifts signal_in into the shift register LSB; after DATA_W-th data bit -> PARITY.
REQ-018 PARITY: sampled bit stored; -> STOP.
REQ-019 STOP: evaluated on the stop-bit edge, always -> IDLE; that bit is never treated as a start bit.
REQ-020 Priority at stop edge: stop bit=1 -> frame_err only; else parity mismatch -> parity_err only; else word is good.
REQ-021 Good word, data_valid=0 or data_ack=1 on the same edge -> data_out loaded, data_valid=1, frame_cnt +1.
REQ-022 Good word, data_valid=1 and data_ack=0 -> data_out/data_valid unchanged, overrun_err pulse, frame_cnt unchanged.
REQ-023 Latency: data_valid and data_out visible immediately after the stop-bit sampling edge (DATA_W+3 edges after the start-bit edge inclusive).
REQ-024 data_ack=1 with data_valid=1 and no good word completing -> data_valid=0 after that edge; data_out retains value.
REQ-025 data_ack while data_valid=0 -> ignored, no state change.
REQ-026 frame_cnt wraps from 2^CNT_W-1 to 0 without any flag.
REQ-027 Error pulses last exactly one CLK; at most one error output high in any cycle.
REQ-028 Back-to-back frames: start bit may arrive on the edge immediately after the stop edge; no idle gap required.

Reset
REQ-029 RST_N=0 asynchronously forces: state IDLE, bit counter 0, shift register 0, data_out 0, data_valid 0, parity_err 0, frame_err 0, overrun_err 0, frame_cnt 0, busy 0.
REQ-030 Reset mid-frame discards the partial frame; after release, reception resumes only on a new start bit sampled in IDLE.

Verification
REQ-031 DATA_W=8, send 1,1010_0101,0,0 (0xA5, parity 0) -> data_out=0xA5, data_valid=1, frame_cnt=1, all errors 0, busy low after stop edge.
REQ-032 Send 0x3C with parity bit 1 -> parity_err one-cycle pulse, data_valid stays 0, frame_cnt=0.
REQ-033 Send 0x81 with stop bit 1 -> frame_err pulse; next cycle state IDLE, no spurious frame started from that bit.
REQ-034 Send 0x11 then 0x22 back-to-back with data_ack held 0 -> data_out=0x11, overrun_err pulse on second stop edge, frame_cnt=1; ack on the same edge as the second stop instead -> data_out=0x22, data_valid=1, frame_cnt=2, no overrun.
REQ-035 Assert RST_N=0 after 4 data bits of a frame, release, send 0x5A -> only 0x5A received, frame_cnt=1.
REQ-036 CNT_W=4, send 17 good frames acking each -> frame_cnt=1 after wrap, no error outputs.
